// File: rtl/display_bcd_pkg.sv
// Shared definitions for the display_bcd block: FSM state encoding, numeric
// limits for decimal and MM:SS display, and the active-low 7-segment glyph table.
package display_bcd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDiv,
    StConvHi,
    StConvLo,
    StUpdate
  } state_e;

  localparam int unsigned NUM_DIGITS  = 4;
  localparam int unsigned MAX_DEC     = 9999;
  localparam int unsigned MAX_MIN     = 99;
  localparam int unsigned SEC_PER_MIN = 60;
  localparam int unsigned MAX_SEC     = SEC_PER_MIN - 1;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost element of the concatenation.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,  // 15..10
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  function automatic logic [6:0] glyph(input logic [3:0] d);
    return GLYPH_TABLE[d];
  endfunction

endpackage

// File: rtl/display_bcd_bin2bcd.sv
// bin2bcd_seq: sequential 16-bit binary to 4-digit BCD converter (shift-add-3).
// A start pulse loads bin_i and performs the first of 16 shift steps in the same
// cycle; done_o pulses for one cycle once the 16th step has been written to bcd_o.
// bcd_o holds its value until the next start.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   start_i : start pulse, samples bin_i
//   bin_i   : binary input (callers keep it <= 9999)
//   done_o  : one-cycle completion pulse
//   bcd_o   : four BCD digits, digit 3 in [15:12]
module bin2bcd_seq (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [15:0] bin_i,
  output logic        done_o,
  output logic [15:0] bcd_o
);

  logic [15:0] bin_q;
  logic [15:0] bcd_q;
  logic [3:0]  cnt_q;
  logic        run_q;
  logic        done_q;

  // One double-dabble step: correct every nibble >= 5, then shift the next bit in.
  function automatic logic [15:0] dabble(input logic [15:0] bcd, input logic bit_in);
    logic [15:0] adj;
    for (int i = 0; i < 4; i++) begin
      adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
    end
    return 16'({adj, bit_in});
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        bcd_q <= dabble(16'h0000, bin_i[15]);
        bin_q <= {bin_i[14:0], 1'b0};
        cnt_q <= 4'd1;
        run_q <= 1'b1;
      end else if (run_q) begin
        bcd_q <= dabble(bcd_q, bin_q[15]);
        bin_q <= {bin_q[14:0], 1'b0};
        cnt_q <= cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/display_bcd.sv
// display_bcd: converts a binary seconds value to four multiplexed 7-segment
// digits, either as decimal 0..9999 or as MM:SS, with saturation and leading
// zero blanking. A conversion is launched whenever {valor,modo} differs from
// the last captured pair; changes during a conversion are picked up afterwards.
//   clk    : clock, all state on rising edge
//   reseta : asynchronous active-low reset
//   valor  : binary seconds value
//   modo   : 0 = decimal, 1 = MM:SS
//   seg    : active-low segments {g,f,e,d,c,b,a}
//   an     : active-low one-hot digit enable, bit 0 = rightmost
//   dp     : active-low decimal point (colon position in MM:SS)
//   busy   : conversion in progress
//   ovf    : displayed value is saturated
module display_bcd
  import display_bcd_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned BLANK_LEAD = 1
) (
  input  logic        clk,
  input  logic        reseta,
  input  logic [15:0] valor,
  input  logic        modo,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic        busy,
  output logic        ovf
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // Conversion FSM state
  state_e      state_q;
  logic        cap_valid_q;
  logic [15:0] last_valor_q;
  logic        last_modo_q;
  logic        busy_q;
  logic        start_q;
  logic [15:0] conv_in_q;
  logic [15:0] dvd_q;
  logic [6:0]  rem_q;
  logic [3:0]  step_q;
  logic [5:0]  secs_q;
  logic [7:0]  hi_q;
  logic        ovf_pend_q;

  // Displayed value, loaded atomically in StUpdate
  logic [NUM_DIGITS*4-1:0] digits_q;
  logic                    disp_mode_q;
  logic                    ovf_q;

  // Scan state and registered outputs
  logic [CntW-1:0] scan_cnt_q;
  logic [1:0]      idx_q;
  logic [3:0]      an_q;
  logic [6:0]      seg_q;
  logic            dp_q;

  logic        trigger;
  logic [7:0]  div_t;
  logic        div_qbit;
  logic [6:0]  div_rem_nxt;
  logic [15:0] div_dvd_nxt;
  logic        conv_start;
  logic [15:0] conv_in;
  logic        conv_done;
  logic [15:0] conv_bcd;
  logic        chain_lo;

  assign trigger = !cap_valid_q || (valor != last_valor_q) || (modo != last_modo_q);

  // One restoring-division step by 60; the dividend register fills with quotient bits.
  always_comb begin
    div_t       = {rem_q, dvd_q[15]};
    div_qbit    = (div_t >= 8'(SEC_PER_MIN));
    div_rem_nxt = div_qbit ? 7'(div_t - 8'(SEC_PER_MIN)) : div_t[6:0];
    div_dvd_nxt = {dvd_q[14:0], div_qbit};
  end

  // Seconds conversion starts on the same edge minutes finish, saving the handoff cycle.
  assign chain_lo   = (state_q == StConvHi) && conv_done;
  assign conv_start = start_q || chain_lo;
  assign conv_in    = chain_lo ? {10'd0, secs_q} : conv_in_q;

  bin2bcd_seq u_bin2bcd (
    .clk_i   (clk),
    .rst_ni  (reseta),
    .start_i (conv_start),
    .bin_i   (conv_in),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  always_ff @(posedge clk or negedge reseta) begin
    if (!reseta) begin
      state_q      <= StIdle;
      cap_valid_q  <= 1'b0;
      last_valor_q <= '0;
      last_modo_q  <= 1'b0;
      busy_q       <= 1'b0;
      start_q      <= 1'b0;
      conv_in_q    <= '0;
      dvd_q        <= '0;
      rem_q        <= '0;
      step_q       <= '0;
      secs_q       <= '0;
      hi_q         <= '0;
      ovf_pend_q   <= 1'b0;
      digits_q     <= '0;
      disp_mode_q  <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (trigger) begin
            cap_valid_q  <= 1'b1;
            last_valor_q <= valor;
            last_modo_q  <= modo;
            busy_q       <= 1'b1;
            if (modo) begin
              state_q <= StDiv;
              dvd_q   <= valor;
              rem_q   <= '0;
              step_q  <= '0;
            end else begin
              state_q <= StConvLo;
              start_q <= 1'b1;
              if (valor > 16'(MAX_DEC)) begin
                conv_in_q  <= 16'(MAX_DEC);
                ovf_pend_q <= 1'b1;
              end else begin
                conv_in_q  <= valor;
                ovf_pend_q <= 1'b0;
              end
            end
          end
        end
        StDiv: begin
          dvd_q  <= div_dvd_nxt;
          rem_q  <= div_rem_nxt;
          step_q <= step_q + 4'd1;
          if (step_q == 4'd15) begin
            state_q <= StConvHi;
            start_q <= 1'b1;
            if (div_dvd_nxt > 16'(MAX_MIN)) begin
              conv_in_q  <= 16'(MAX_MIN);
              secs_q     <= 6'(MAX_SEC);
              ovf_pend_q <= 1'b1;
            end else begin
              conv_in_q  <= div_dvd_nxt;
              secs_q     <= div_rem_nxt[5:0];
              ovf_pend_q <= 1'b0;
            end
          end
        end
        StConvHi: begin
          if (conv_done) begin
            hi_q    <= conv_bcd[7:0];
            state_q <= StConvLo;
          end
        end
        StConvLo: begin
          if (conv_done) begin
            state_q <= StUpdate;
          end
        end
        StUpdate: begin
          digits_q    <= last_modo_q ? {hi_q, conv_bcd[7:0]} : conv_bcd;
          disp_mode_q <= last_modo_q;
          ovf_q       <= ovf_pend_q;
          busy_q      <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Digit scan output decode
  logic [3:0] cur_digit;
  logic       blank;
  logic [3:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;

  always_comb begin
    cur_digit = digits_q[{idx_q, 2'b00} +: 4];
    blank     = 1'b0;
    // Blank when this digit and every digit above it are zero; digit 0 always shows.
    if (!disp_mode_q && (BLANK_LEAD != 0) && (idx_q != 2'd0)) begin
      blank = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if ((i >= int'(idx_q)) && (digits_q[i*4 +: 4] != 4'd0)) begin
          blank = 1'b0;
        end
      end
    end
    an_d  = ~(4'b0001 << idx_q);
    seg_d = blank ? SEG_BLANK : glyph(cur_digit);
    dp_d  = !(disp_mode_q && (idx_q == 2'd2));
  end

  always_ff @(posedge clk or negedge reseta) begin
    if (!reseta) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      an_q       <= 4'hF;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
    end else begin
      if (scan_cnt_q == CntW'(SCAN_DIV - 1)) begin
        scan_cnt_q <= '0;
        idx_q      <= idx_q + 2'd1;
      end else begin
        scan_cnt_q <= scan_cnt_q + CntW'(1);
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign dp   = dp_q;
  assign busy = busy_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_display_bcd.sv
module tb_display_bcd;

  logic        clk = 1'b0;
  logic        reseta;
  logic [15:0] valor;
  logic        modo;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic        busy;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

  display_bcd #(
    .SCAN_DIV   (4),
    .BLANK_LEAD (1)
  ) dut (
    .clk    (clk),
    .reseta (reseta),
    .valor  (valor),
    .modo   (modo),
    .seg    (seg),
    .an     (an),
    .dp     (dp),
    .busy   (busy),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  // Counts negedge samples with busy high; returns once busy drops (bounded).
  task automatic run_conv(output int cycles);
    cycles = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) cycles++;
      else if (cycles > 0) break;
    end
  endtask

  // Records seg/dp seen for each digit enable over more than one full scan.
  task automatic scan_capture(output logic [3:0][6:0] segs, output logic [3:0] dps);
    segs = {4{7'bx}};
    dps  = 4'bx;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        if (an == ~(4'b0001 << d)) begin
          segs[d] = seg;
          dps[d]  = dp;
        end
      end
    end
  endtask

  task automatic start_conv(input logic [15:0] v, input logic m);
    @(negedge clk);
    valor = v;
    modo  = m;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an got %h want f", an); end
    n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg got %h want 7f", seg); end
    n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp got %b want 1", dp); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
  endtask

  task automatic test_post_reset();
    int cyc;
    logic [3:0][6:0] s;
    logic [3:0] d;
    logic [3:0][6:0] exp_s;
    exp_s = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    @(negedge clk);
    reseta = 1'b1;
    run_conv(cyc);
    n_checks++; if (cyc !== 18) begin n_fail++; $display("FAIL post_reset_busy got %0d want 18", cyc); end
    scan_capture(s, d);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (s[i] !== exp_s[i]) begin
        n_fail++; $display("FAIL post_reset_seg[%0d] got %h want %h", i, s[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_scan();
    logic [3:0] exp_an;
    int guard;
    guard = 0;
    while (an !== 4'b0111 && guard < 40) begin @(negedge clk); guard++; end
    while (an === 4'b0111 && guard < 40) begin @(negedge clk); guard++; end
    for (int j = 0; j < 16; j++) begin
      exp_an = ~(4'b0001 << (j / 4));
      n_checks++;
      if (an !== exp_an) begin
        n_fail++; $display("FAIL scan_an[%0d] got %b want %b", j, an, exp_an);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_dec_1234();
    int cyc;
    logic [3:0][6:0] s;
    logic [3:0] d;
    logic [3:0][6:0] exp_s;
    exp_s = {7'h79, 7'h24, 7'h30, 7'h19};
    start_conv(16'd1234, 1'b0);
    run_conv(cyc);
    n_checks++; if (cyc !== 18) begin n_fail++; $display("FAIL dec1234_busy got %0d want 18", cyc); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL dec1234_ovf got %b want 0", ovf); end
    scan_capture(s, d);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (s[i] !== exp_s[i]) begin
        n_fail++; $display("FAIL dec1234_seg[%0d] got %h want %h", i, s[i], exp_s[i]);
      end
    end
    n_checks++; if (d !== 4'hF) begin n_fail++; $display("FAIL dec1234_dp got %b want 1111", d); end
  endtask

  task automatic test_blank_42();
    int cyc;
    logic [3:0][6:0] s;
    logic [3:0] d;
    logic [3:0][6:0] exp_s;
    exp_s = {7'h7F, 7'h7F, 7'h19, 7'h24};
    start_conv(16'd42, 1'b0);
    run_conv(cyc);
    scan_capture(s, d);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (s[i] !== exp_s[i]) begin
        n_fail++; $display("FAIL blank42_seg[%0d] got %h want %h", i, s[i], exp_s[i]);
      end
    end
    n_checks++; if (d !== 4'hF) begin n_fail++; $display("FAIL blank42_dp got %b want 1111", d); end
  endtask

  task automatic test_sat_dec();
    int cyc;
    logic [3:0][6:0] s;
    logic [3:0] d;
    logic [3:0][6:0] exp_s;
    exp_s = {7'h10, 7'h10, 7'h10, 7'h10};
    start_conv(16'd10000, 1'b0);
    run_conv(cyc);
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL sat9999_ovf got %b want 1", ovf); end
    scan_capture(s, d);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (s[i] !== exp_s[i]) begin
        n_fail++; $display("FAIL sat9999_seg[%0d] got %h want %h", i, s[i], exp_s[i]);
      end
    end
    exp_s = {7'h7F, 7'h7F, 7'h7F, 7'h78};
    start_conv(16'd7, 1'b0);
    run_conv(cyc);
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL dec7_ovf got %b want 0", ovf); end
    scan_capture(s, d);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (s[i] !== exp_s[i]) begin
        n_fail++; $display("FAIL dec7_seg[%0d] got %h want %h", i, s[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_mmss_125();
    int cyc;
    logic [3:0][6:0] s;
    logic [3:0] d;
    logic [3:0][6:0] exp_s;
    exp_s = {7'h40, 7'h24, 7'h40, 7'h12};
    start_conv(16'd125, 1'b1);
    run_conv(cyc);
    n_checks++; if (cyc !== 50) begin n_fail++; $display("FAIL mmss125_busy got %0d want 50", cyc); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL mmss125_ovf got %b want 0", ovf); end
    scan_capture(s, d);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (s[i] !== exp_s[i]) begin
        n_fail++; $display("FAIL mmss125_seg[%0d] got %h want %h", i, s[i], exp_s[i]);
      end
    end
    n_checks++; if (d !== 4'b1011) begin n_fail++; $display("FAIL mmss125_dp got %b want 1011", d); end
  endtask

  task automatic test_mmss_sat();
    int cyc;
    logic [3:0][6:0] s;
    logic [3:0] d;
    logic [3:0][6:0] exp_s;
    exp_s = {7'h10, 7'h10, 7'h12, 7'h10};
    start_conv(16'd6000, 1'b1);
    run_conv(cyc);
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL mmss_sat_ovf got %b want 1", ovf); end
    scan_capture(s, d);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (s[i] !== exp_s[i]) begin
        n_fail++; $display("FAIL mmss_sat_seg[%0d] got %h want %h", i, s[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [3:0][6:0] s;
    logic [3:0] d;
    logic [3:0][6:0] exp_s;
    start_conv(16'd125, 1'b1);
    repeat (10) @(negedge clk);
    valor = 16'd126;
    run_conv(cyc);
    n_checks++; if (cyc !== 40) begin n_fail++; $display("FAIL b2b_first_busy got %0d want 40", cyc); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_retrigger got %b want 1", busy); end
    exp_s = {7'h40, 7'h24, 7'h40, 7'h12};
    scan_capture(s, d);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (s[i] !== exp_s[i]) begin
        n_fail++; $display("FAIL b2b_first_seg[%0d] got %h want %h", i, s[i], exp_s[i]);
      end
    end
    run_conv(cyc);
    exp_s = {7'h40, 7'h24, 7'h40, 7'h02};
    scan_capture(s, d);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (s[i] !== exp_s[i]) begin
        n_fail++; $display("FAIL b2b_second_seg[%0d] got %h want %h", i, s[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_reset_mid_div();
    int cyc;
    logic [3:0][6:0] s;
    logic [3:0] d;
    logic [3:0][6:0] exp_s;
    exp_s = {7'h79, 7'h40, 7'h40, 7'h40};
    start_conv(16'd600, 1'b1);
    repeat (5) @(negedge clk);
    reseta = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL rst_mid_an got %h want f", an); end
    n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL rst_mid_seg got %h want 7f", seg); end
    n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL rst_mid_dp got %b want 1", dp); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ovf got %b want 0", ovf); end
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_hold_busy got %b want 0", busy); end
    n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL rst_hold_an got %h want f", an); end
    reseta = 1'b1;
    run_conv(cyc);
    n_checks++; if (cyc !== 50) begin n_fail++; $display("FAIL rst_rel_busy got %0d want 50", cyc); end
    scan_capture(s, d);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (s[i] !== exp_s[i]) begin
        n_fail++; $display("FAIL rst_rel_seg[%0d] got %h want %h", i, s[i], exp_s[i]);
      end
    end
    n_checks++; if (d !== 4'b1011) begin n_fail++; $display("FAIL rst_rel_dp got %b want 1011", d); end
  endtask

  initial begin
    reseta = 1'b0;
    valor  = 16'd0;
    modo   = 1'b0;
    test_reset();
    test_post_reset();
    test_scan();
    test_dec_1234();
    test_blank_42();
    test_sat_dec();
    test_mmss_125();
    test_mmss_sat();
    test_back_to_back();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_bcd.md
DISPLAY_BCD -- requirements
Module: display_bcd

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles per digit-scan step (1 kHz digit rate at 50 MHz).
REQ-002 SHALL have parameter BLANK_LEAD, default 1; 1 blanks leading zeros in decimal mode.
REQ-003 SHALL have port clk  in  1  single clock; all state on its rising edge.
REQ-004 SHALL have port reseta  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port valor  in  16  binary seconds value from contador (aux).
REQ-006 SHALL have port modo  in  1  0 = decimal 0..9999, 1 = MM:SS.
REQ-007 SHALL have port seg  out  7  active-low segments {g,f,e,d,c,b,a}.
REQ-008 SHALL have port an  out  4  active-low one-hot digit enables; bit 0 = rightmost digit.
REQ-009 SHALL have port dp  out  1  active-low decimal point.
REQ-010 SHALL have port busy  out  1  high while a conversion is in progress.
REQ-011 SHALL have port ovf  out  1  high when the displayed value is saturated.

Function
REQ-012 SHALL use FSM states IDLE, DIV, CONV_HI, CONV_LO, UPDATE.
REQ-013 In IDLE, a trigger SHALL occur when {valor,modo} differs from the last captured pair, or when no capture has happened since reset; on a trigger the FSM captures {valor,modo} and goes to CONV_LO (modo=0) or DIV (modo=1).
REQ-014 DIV SHALL take 16 cycles of restoring division of the captured value by 60, giving minutes = quotient and secs = remainder.
REQ-015 Mode 0 SHALL saturate: a captured value >9999 converts as 9999 with ovf=1; otherwise it runs one 16-cycle shift-add-3 conversion in CONV_LO, producing 4 BCD digits.
REQ-016 Mode 1 SHALL saturate: minutes >99 gives 99:59 with ovf=1; CONV_HI (16 cycles) converts minutes to digits 3..2, then CONV_LO (16 cycles) converts secs to digits 1..0.
REQ-017 UPDATE SHALL last 1 cycle; it loads the displayed-digit registers, ovf and the display mode together (no partially updated digits), then returns to IDLE.
REQ-018 Latency SHALL be measured from the trigger edge k: digits valid after edge k+18 (mode 0) and k+50 (mode 1).
REQ-019 busy SHALL be 1 from edge k through the end of the UPDATE cycle, and 0 in IDLE.
REQ-020 Changes to valor or modo while busy SHALL be ignored; a mismatch still present on return to IDLE triggers a new conversion, so the final value is always displayed.
REQ-021 The scan divider SHALL count 0..SCAN_DIV-1; on wrap, the digit index increments 0->1->2->3->0, with no gap cycles between digits.
REQ-022 an SHALL be ~(1<<index); seg SHALL be the active-low glyph of the displayed digit at that index.
REQ-023 In decimal mode with BLANK_LEAD=1, a digit SHALL be blanked (seg=7'h7F) when it and all digits above it are zero; digit 0 is never blanked.
REQ-024 dp SHALL be 0 only when the display mode is MM:SS and index=2; otherwise dp=1.
REQ-025 Digit codes 10..15 SHALL map to blank.

Reset
REQ-026 While reseta=0, outputs SHALL be: an=4'hF, seg=7'h7F, dp=1, busy=0, ovf=0.
REQ-027 While reseta=0, internal state SHALL be: FSM=IDLE, digits=0, divider=0, index=0, capture-valid=0.
REQ-028 Reset assertion mid-conversion SHALL abort the conversion immediately.
REQ-029 After release, the first rising edge SHALL trigger a conversion of the current inputs.

Structure
REQ-030 A shared package SHALL hold the state enum, NUM_DIGITS=4, MAX_DEC=9999, MAX_MIN=99, SEC_PER_MIN=60, and the 16-entry glyph table (0 = 7'b1000000 ... 9 = 7'b0010000, 10..15 = 7'h7F).
REQ-031 Sub-module bin2bcd_seq SHALL be the 16-cycle shift-add-3 converter, used for both CONV phases via a start/done handshake.

Verification
REQ-032 valor=1234, modo=0 -> digits 1,2,3,4 after k+18; busy high for 18 cycles; ovf=0.
REQ-033 valor=42, modo=0, BLANK_LEAD=1 -> digits 3..2 blank, digits 1..0 = 4,2; dp=1 on all digits.
REQ-034 valor=10000, modo=0 -> 9999 with ovf=1; then valor=7 -> 7 with ovf=0.
REQ-035 valor=125, modo=1 -> 02:05 after k+50; dp=0 only while an=4'b1011.
REQ-036 valor=6000, modo=1 -> 99:59 with ovf=1.
REQ-037 Change valor 125->126 at cycle k+10 -> 02:05 appears first, then 02:06 after a second conversion.
REQ-038 Pulse reseta low mid-DIV -> all reset values hold during reset; the current value converts after release.
REQ-039 With SCAN_DIV=4, an SHALL cycle 1110, 1101, 1011, 0111, holding each for 4 cycles.
